// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mem_arb_pkg
// Brief    : State encoding and default widths for the memory port arbiter.
// Revision : 1.0
// ============================================================================
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef logic [2:0] arbState_t;

    localparam arbState_t IDLE   = 3'd0;
    localparam arbState_t BUSY_I = 3'd1;
    localparam arbState_t BUSY_D = 3'd2;
    localparam arbState_t DONE_I = 3'd3;
    localparam arbState_t DONE_D = 3'd4;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Serialises IF fetch and MEM load/store onto one variable-latency
//            memory port, with a bounded-wait timer and anti-starvation.
// Revision : 1.0
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int TIMEOUT      = 64,
    parameter int MAX_DATA_RUN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_ok,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_ok,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              stall,
    output logic              timeout_err
);

    localparam int RUN_W  = (MAX_DATA_RUN > 0) ? $clog2(MAX_DATA_RUN + 1) : 1;
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [RUN_W-1:0]  c_RUN_MAX   = RUN_W'(MAX_DATA_RUN);
    localparam logic [WAIT_W-1:0] c_WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam bit                c_TIMER_ON  = (TIMEOUT != 0);

    arbState_t         r_state;
    arbState_t         w_nextState;
    logic              w_grantI;
    logic              w_grantD;
    logic              w_finish;
    logic              w_timeout;

    logic [RUN_W-1:0]  r_dataRun;
    logic [WAIT_W-1:0] r_waitCnt;
    logic              r_memReq;
    logic              r_memWe;
    logic [ADDR_W-1:0] r_memAddr;
    logic [DATA_W-1:0] r_memWdata;
    logic [DATA_W-1:0] r_instRdata;
    logic [DATA_W-1:0] r_dataRdata;
    logic              r_instOk;
    logic              r_dataOk;
    logic              r_timeoutErr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Data wins ties (older instruction) unless it has already won MAX_DATA_RUN
    // grants in a row while a fetch was waiting.
    always_comb begin
        w_nextState = r_state;
        w_grantI    = 1'b0;
        w_grantD    = 1'b0;
        w_finish    = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE: begin
                if (data_req && ((r_dataRun < c_RUN_MAX) || !inst_req)) begin
                    w_grantD    = 1'b1;
                    w_nextState = BUSY_D;
                end else if (inst_req) begin
                    w_grantI    = 1'b1;
                    w_nextState = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ready) begin
                    w_finish = 1'b1;
                end else if (c_TIMER_ON && (r_waitCnt == c_WAIT_LAST)) begin
                    w_finish  = 1'b1;
                    w_timeout = 1'b1;
                end
                if (w_finish) begin
                    w_nextState = (r_state == BUSY_I) ? DONE_I : DONE_D;
                end
            end
            DONE_I, DONE_D: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dataRun    <= '0;
            r_waitCnt    <= '0;
            r_memReq     <= 1'b0;
            r_memWe      <= 1'b0;
            r_memAddr    <= '0;
            r_memWdata   <= '0;
            r_instRdata  <= '0;
            r_dataRdata  <= '0;
            r_instOk     <= 1'b0;
            r_dataOk     <= 1'b0;
            r_timeoutErr <= 1'b0;
        end else begin
            r_instOk <= (w_nextState == DONE_I);
            r_dataOk <= (w_nextState == DONE_D);

            if (w_grantD) begin
                r_memReq   <= 1'b1;
                r_memWe    <= data_we;
                r_memAddr  <= data_addr;
                r_memWdata <= data_wdata;
                r_waitCnt  <= '0;
            end else if (w_grantI) begin
                r_memReq   <= 1'b1;
                r_memWe    <= 1'b0;
                r_memAddr  <= inst_addr;
                r_memWdata <= '0;
                r_waitCnt  <= '0;
            end else if (w_finish) begin
                r_memReq <= 1'b0;
            end else if ((r_state == BUSY_I) || (r_state == BUSY_D)) begin
                r_waitCnt <= r_waitCnt + 1'b1;
            end

            // A timed-out access returns zero; a completed store leaves read data alone.
            if (w_finish) begin
                if (r_state == BUSY_I) begin
                    r_instRdata <= w_timeout ? '0 : mem_rdata;
                end else if (w_timeout) begin
                    r_dataRdata <= '0;
                end else if (!r_memWe) begin
                    r_dataRdata <= mem_rdata;
                end
            end

            if (w_timeout) begin
                r_timeoutErr <= 1'b1;
            end

            if (w_grantI) begin
                r_dataRun <= '0;
            end else if (w_grantD) begin
                if (!inst_req) begin
                    r_dataRun <= '0;
                end else if (r_dataRun != c_RUN_MAX) begin
                    r_dataRun <= r_dataRun + 1'b1;
                end
            end
        end
    end

    assign mem_req     = r_memReq;
    assign mem_we      = r_memWe;
    assign mem_addr    = r_memAddr;
    assign mem_wdata   = r_memWdata;
    assign inst_rdata  = r_instRdata;
    assign data_rdata  = r_dataRdata;
    assign inst_ok     = r_instOk;
    assign data_ok     = r_dataOk;
    assign timeout_err = r_timeoutErr;
    assign stall       = (inst_req & ~r_instOk) | (data_req & ~r_dataOk);

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbitrates one single-port, variable-latency memory between the IF-stage instruction fetch and the MEM-stage load/store of the 5-stage pipeline. It serialises the two requesters and registers the memory request. It returns read data with a one-cycle `ok` pulse and raises `stall` so the hazard logic holds the pipeline (drives StallF/StallD) while an access is outstanding. A bounded-wait timer guarantees forward progress if memory never answers.

Parameters:
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.
- `TIMEOUT`, 64, max cycles in a BUSY state waiting for `mem_ready`; 0 disables the timer.
- `MAX_DATA_RUN`, 4, consecutive data grants allowed while `inst_req` is pending before the instruction side is forced.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `inst_req` in 1: fetch request, held until `inst_ok`.
- `inst_addr` in ADDR_W: fetch address (PCF).
- `inst_rdata` out DATA_W: fetched instruction (InstF).
- `inst_ok` out 1: one-cycle completion pulse.
- `data_req` in 1: load/store request, held until `data_ok`.
- `data_we` in 1: 1 = store.
- `data_addr` in ADDR_W: ALUResultM.
- `data_wdata` in DATA_W: WriteDataM.
- `data_rdata` out DATA_W: ReadDataM.
- `data_ok` out 1: one-cycle completion pulse.
- `mem_req` out 1: memory request, level, held until `mem_ready`.
- `mem_we` out 1.
- `mem_addr` out ADDR_W.
- `mem_wdata` out DATA_W.
- `mem_rdata` in DATA_W: valid when `mem_ready`=1.
- `mem_ready` in 1: access complete (single-cycle).
- `stall` out 1: access pending, not yet completed.
- `timeout_err` out 1: sticky; a timeout occurred.

Behaviour:
- Reset (async, `rst`=1): state IDLE; `data_run`=0, `wait_cnt`=0. All outputs 0: `mem_*`, `*_rdata`, `*_ok`, `timeout_err`. `stall` follows its equation.
- Reset mid-access: the transaction is abandoned and `mem_req` falls immediately (async). No `ok` is issued.
- States: IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D.
- IDLE arbitration (registered):
  - If `data_req` and (`data_run`<MAX_DATA_RUN or !`inst_req`): go to BUSY_D.
  - Else if `inst_req`: go to BUSY_I.
  - Else stay in IDLE.
  - Data has priority because it is the older instruction.
- Grant:
  - Latch the granted side's addr/wdata/we into the `mem_*` registers. `mem_req`=1 from the first BUSY cycle.
  - An inst grant latches `mem_we`=0 and `mem_wdata`=0.
- `data_run`:
  - +1 on a data grant while `inst_req`=1.
  - Cleared on an inst grant, or on a data grant with `inst_req`=0.
  - Saturates at MAX_DATA_RUN.
- BUSY_x, `mem_ready`=1:
  - Capture `mem_rdata` into `x_rdata` (stores capture nothing; `data_rdata` keeps its old value).
  - Drop `mem_req`; go to DONE_x.
- BUSY_x, no `mem_ready`:
  - `wait_cnt`++.
  - If TIMEOUT≠0 and `wait_cnt`==TIMEOUT-1: set `timeout_err`, `x_rdata`=0, drop `mem_req`, go to DONE_x.
  - If `mem_ready` and the timeout fall in the same cycle, `mem_ready` wins and no error is raised.
- DONE_x: `x_ok`=1 for exactly this cycle, then go to IDLE. No grant is made in DONE.
- `wait_cnt` clears on entry to BUSY.
- Latency: req sampled in IDLE at cycle 0 → `mem_req` at cycle 1 → `mem_ready` at cycle 1+k (k≥0) → `x_ok` at cycle 2+k. Minimum 3 cycles per access.
- Requester rule: req and fields stay stable until `ok`. After `ok` the requester may deassert or present a new request, which is sampled in the following IDLE cycle. A req dropped before `ok` is illegal (assertion in the bench).
- `mem_addr`/`mem_we`/`mem_wdata` hold their values outside BUSY; they are only meaningful while `mem_req`=1.
- `stall` = (`inst_req` & !`inst_ok`) | (`data_req` & !`data_ok`), combinational from registered ok.
- `timeout_err` clears only on `rst`.

Decomposition:
- Shared package `mem_arb_pkg`: state encoding localparams (IDLE=3'd0, BUSY_I=3'd1, BUSY_D=3'd2, DONE_I=3'd3, DONE_D=3'd4) and the ADDR_W/DATA_W defaults.
- No sub-module is needed; the wait timer is a plain counter inside the block.

Test Plan:
- Inst only: `inst_req`=1 with addr 0x0000_0040; memory answers with k=0 and rdata 0x2010_0005. Expect `mem_req` at cycle 1, `inst_ok` at cycle 2, `inst_rdata`=0x2010_0005, `stall`=0 from cycle 3.
- Simultaneous request: inst 0x0000_0044 and data store 0x1000_0008 with wdata 0xDEAD_BEEF. Expect the data side is served first (`mem_we`=1, `mem_addr`=0x1000_0008), then inst. `data_ok` precedes `inst_ok` by at least 3 cycles.
- Starvation: `inst_req` held high; 6 back-to-back data loads. Expect grants D,D,D,D,I,D,D with MAX_DATA_RUN=4.
- Timeout: with TIMEOUT=8, hold `mem_ready`=0. Expect `mem_req` to drop after 8 BUSY cycles, `data_ok` pulse with `data_rdata`=0, `timeout_err`=1 until reset. A later access completes normally.
- Race: `mem_ready` in the same cycle the timeout expires. Expect rdata captured and `timeout_err` stays 0.
- Async reset at cycle 1+2 of a load with k=5. Expect `mem_req`=0 immediately, no `data_ok`, state IDLE. A re-issued request is served normally after release.
